// File: rtl/cdc_fifo_rd_fwft.sv
// rtl/cdc_fifo_rd_fwft.sv - read-side FWFT output stage of the async CDC FIFO
//
// Turns the 1-cycle-latency FIFO memory read port into a first-word-fall-through
// valid/ready stream. An output register plus a skid register absorb the
// read latency so one word per cycle is sustained under continuous m_ready.
//
// Ports:
//   r_clk      read-domain clock
//   r_rst_n    asynchronous active-low reset (shared with read-pointer logic)
//   r_empty    registered FIFO empty flag
//   r_inc      read request; pointer advances on r_inc & ~r_empty
//   r_rd_data  memory read data, valid the cycle after an accepted read
//   m_valid    stream word available
//   m_ready    downstream accepts word
//   m_data     stream word

module cdc_fifo_rd_fwft #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  r_empty,
    output logic                  r_inc,
    input  logic [DATA_WIDTH-1:0] r_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  skid_vld_q, skid_vld_d;
    logic                  infl_q, infl_d;

    logic       pop;
    logic       accept;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;

    assign pop = out_vld_q & m_ready;

    // Words held or already requested; never exceeds 2, so 2 bits suffice.
    assign occ           = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, infl_q};
    assign occ_after_pop = occ - {1'b0, pop};

    // Request only when there will be room for the returning word. Gated by
    // reset so no pointer movement is requested while the block is held.
    assign r_inc  = r_rst_n & ~r_empty & (occ_after_pop < 2'd2);
    assign accept = r_inc & ~r_empty;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        infl_d     = accept;

        // Pop first: the skid word, being older than any landing word,
        // refills the output register.
        if (pop) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d  = 1'b0;
            end
        end

        // Landing word goes to whichever slot is free after the pop.
        if (infl_q) begin
            if (!out_vld_d) begin
                out_d      = r_rd_data;
                out_vld_d  = 1'b1;
            end else begin
                skid_d     = r_rd_data;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            infl_q     <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            infl_q     <= infl_d;
        end
    end

    assign m_valid = out_vld_q;
    assign m_data  = out_q;

endmodule
